// File: rtl/transmissor_relatorio_serial_if.sv
// Handshake and data bundle between the control unit and the serial report transmitter.
interface transmissor_relatorio_serial_if;
    logic        partida;
    logic [15:0] peso_atual;
    logic        pertence_intervalo;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  db_estado;

    modport master (
        output partida, peso_atual, pertence_intervalo,
        input  saida_serial, ocupado, pronto, db_estado
    );
    modport slave (
        input  partida, peso_atual, pertence_intervalo,
        output saida_serial, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/transmissor_relatorio_serial.sv
// 8N1 transmitter sending a 5-byte ASCII weight/interval report per start request.
module transmissor_relatorio_serial #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    transmissor_relatorio_serial_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0, INICIO = 3'd1, DADOS = 3'd2, PARADA = 3'd3, FIM = 3'd4
    } estadoT;

    estadoT        estado, estadoProx;
    logic [CW-1:0] baudCnt, baudProx;
    logic [2:0]    bitIdx, bitProx;
    logic [2:0]    byteIdx, byteProx;
    logic [7:0]    dezena, dezenaProx;
    logic [7:0]    unidade, unidadeProx;
    logic          flag, flagProx;
    logic          linhaQ, linhaProx;
    logic          ocupadoQ, ocupadoProx;
    logic          prontoQ, prontoProx;
    logic          fimBit, aceita;
    logic [7:0]    byteAtual;

    function automatic logic [7:0] digitoAscii(input logic [7:0] d);
        return (d > 8'd9) ? 8'h3F : 8'h30 + d;
    endfunction

    function automatic logic [7:0] byteQuadro(input logic [2:0] idx, input logic [7:0] dez,
                                              input logic [7:0] uni, input logic flg);
        case (idx)
            3'd0:    return digitoAscii(dez);
            3'd1:    return digitoAscii(uni);
            3'd2:    return 8'h2C;
            3'd3:    return flg ? 8'h31 : 8'h30;
            default: return 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            baudCnt  <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            dezena   <= '0;
            unidade  <= '0;
            flag     <= 1'b0;
            linhaQ   <= 1'b1;
            ocupadoQ <= 1'b0;
            prontoQ  <= 1'b0;
        end else begin
            estado   <= estadoProx;
            baudCnt  <= baudProx;
            bitIdx   <= bitProx;
            byteIdx  <= byteProx;
            dezena   <= dezenaProx;
            unidade  <= unidadeProx;
            flag     <= flagProx;
            linhaQ   <= linhaProx;
            ocupadoQ <= ocupadoProx;
            prontoQ  <= prontoProx;
        end
    end

    assign fimBit = (baudCnt == BAUD_MAX);

    always_comb begin
        estadoProx  = estado;
        baudProx    = baudCnt;
        bitProx     = bitIdx;
        byteProx    = byteIdx;
        dezenaProx  = dezena;
        unidadeProx = unidade;
        flagProx    = flag;
        aceita      = 1'b0;
        case (estado)
            OCIOSO: aceita = bus.partida;
            INICIO: begin
                if (fimBit) begin
                    estadoProx = DADOS;
                    baudProx   = '0;
                    bitProx    = '0;
                end else baudProx = baudCnt + 1'b1;
            end
            DADOS: begin
                if (fimBit) begin
                    baudProx = '0;
                    if (bitIdx == 3'd7) estadoProx = PARADA;
                    else                bitProx    = bitIdx + 3'd1;
                end else baudProx = baudCnt + 1'b1;
            end
            PARADA: begin
                if (fimBit) begin
                    baudProx = '0;
                    if (byteIdx == 3'd4) estadoProx = FIM;
                    else begin
                        estadoProx = INICIO;
                        byteProx   = byteIdx + 3'd1;
                    end
                end else baudProx = baudCnt + 1'b1;
            end
            FIM: begin
                aceita     = bus.partida;
                estadoProx = OCIOSO;
            end
            default: estadoProx = OCIOSO;
        endcase
        if (aceita) begin
            estadoProx  = INICIO;
            baudProx    = '0;
            bitProx     = '0;
            byteProx    = '0;
            dezenaProx  = bus.peso_atual[15:8];
            unidadeProx = bus.peso_atual[7:0];
            flagProx    = bus.pertence_intervalo;
        end
    end

    // Outputs are computed from the next state so the registered line changes on the same edge as the state.
    always_comb begin
        byteAtual   = byteQuadro(byteProx, dezenaProx, unidadeProx, flagProx);
        linhaProx   = 1'b1;
        ocupadoProx = 1'b0;
        prontoProx  = 1'b0;
        case (estadoProx)
            INICIO: begin linhaProx = 1'b0;               ocupadoProx = 1'b1; end
            DADOS:  begin linhaProx = byteAtual[bitProx]; ocupadoProx = 1'b1; end
            PARADA: ocupadoProx = 1'b1;
            FIM:    prontoProx  = 1'b1;
            default: ;
        endcase
    end

    assign bus.saida_serial = linhaQ;
    assign bus.ocupado      = ocupadoQ;
    assign bus.pronto       = prontoQ;
    assign bus.db_estado    = estado;
endmodule

// File: tb/tb_transmissor_relatorio_serial.sv
// Directed bench for the serial report transmitter with CLKS_PER_BIT = 4.
module tb_transmissor_relatorio_serial;
    localparam int CPB = 4;
    localparam int FRAME = 50 * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nCmp = 0;
    int   nBad = 0;

    logic lineH [0:449];
    logic ocH   [0:449];
    logic prH   [0:449];

    transmissor_relatorio_serial_if bus ();

    transmissor_relatorio_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample n cycles after the start edge; hookKind 1 = change weight, 2 = partida pulse, 3 = reset pulse.
    task automatic capture(input int n, input bit hold, input int hookAt, input int hookKind);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == 0 && !hold) bus.partida = 1'b0;
            lineH[i] = bus.saida_serial;
            ocH[i]   = bus.ocupado;
            prH[i]   = bus.pronto;
            if (i == hookAt) begin
                if (hookKind == 1) bus.peso_atual = 16'h0909;
                if (hookKind == 2) bus.partida = 1'b1;
                if (hookKind == 3) reset = 1'b1;
            end
            if (i == hookAt + 1) begin
                if (hookKind == 2) bus.partida = 1'b0;
                if (hookKind == 3) reset = 1'b0;
            end
        end
    endtask

    // Every cycle of each bit is checked, so wrong bit widths or misplaced edges show as bad framing.
    task automatic checkFrame(input string tag, input int off, input logic [39:0] expBytes);
        logic [7:0] b;
        int         badFraming;
        for (int i = 0; i < 5; i++) begin
            badFraming = 0;
            b = 8'h00;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    int t;
                    t = off + (i * 10 + k) * CPB + c;
                    if (k == 0 && lineH[t] !== 1'b0) badFraming++;
                    if (k == 9 && lineH[t] !== 1'b1) badFraming++;
                    if (k >= 1 && k <= 8) begin
                        if (c == 0) b[k-1] = lineH[t];
                        else if (lineH[t] !== b[k-1]) badFraming++;
                    end
                end
            end
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, b}, {24'h0, expBytes[39-8*i -: 8]});
            chk($sformatf("%s_framing%0d", tag, i), badFraming, 0);
        end
    endtask

    task automatic startFrame(input logic [15:0] peso, input logic flg);
        @(negedge clock);
        bus.peso_atual         = peso;
        bus.pertence_intervalo = flg;
        bus.partida            = 1'b1;
    endtask

    initial begin
        int cntOc, cntPr, badEdge;
        bus.partida            = 1'b0;
        bus.peso_atual         = 16'h0000;
        bus.pertence_intervalo = 1'b0;

        // reset values
        repeat (3) @(negedge clock);
        chk("rst_line", bus.saida_serial, 1);
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_pronto", bus.pronto, 0);
        chk("rst_estado", bus.db_estado, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // basic frame plus bit timing
        startFrame(16'h0407, 1'b1);
        capture(210, 1'b0, -5, 0);
        chk("basic_start_low", lineH[0], 0);
        checkFrame("basic", 0, 40'h34_37_2C_31_0A);
        cntOc = 0; cntPr = 0; badEdge = 0;
        for (int t = 0; t < 210; t++) begin
            if (ocH[t]) cntOc++;
            if (prH[t]) cntPr++;
            if (t > 0 && lineH[t] !== lineH[t-1] && (t % CPB) != 0) badEdge++;
        end
        chk("basic_ocupado_cycles", cntOc, FRAME);
        chk("basic_pronto_cycles", cntPr, 1);
        chk("basic_pronto_at_end", prH[FRAME], 1);
        chk("basic_ocupado_last", ocH[FRAME-1], 1);
        chk("basic_edge_alignment", badEdge, 0);
        chk("basic_idle_after", lineH[FRAME+1], 1);
        chk("basic_estado_idle", bus.db_estado, 0);

        // out-of-range tens digit, weight changed mid-frame
        startFrame(16'h0C00, 1'b0);
        capture(205, 1'b0, 50, 1);
        checkFrame("range", 0, 40'h3F_30_2C_30_0A);

        // partida pulse during byte 2 is ignored
        startFrame(16'h0407, 1'b0);
        capture(260, 1'b0, 90, 2);
        checkFrame("busy", 0, 40'h34_37_2C_30_0A);
        cntOc = 0; cntPr = 0;
        for (int t = 0; t < 260; t++) begin
            if (ocH[t]) cntOc++;
            if (prH[t]) cntPr++;
        end
        chk("busy_ocupado_cycles", cntOc, FRAME);
        chk("busy_pronto_cycles", cntPr, 1);
        chk("busy_line_idle", lineH[259], 1);

        // back-to-back with partida held high
        startFrame(16'h0908, 1'b1);
        capture(2 * FRAME + 2, 1'b1, -5, 0);
        bus.partida = 1'b0;
        checkFrame("b2b_first", 0, 40'h39_38_2C_31_0A);
        checkFrame("b2b_second", FRAME + 1, 40'h39_38_2C_31_0A);
        chk("b2b_gap_high", lineH[FRAME], 1);
        chk("b2b_gap_not_busy", ocH[FRAME], 0);
        chk("b2b_restart_low", lineH[FRAME+1], 0);
        chk("b2b_restart_busy", ocH[FRAME+1], 1);
        chk("b2b_second_pronto", prH[2*FRAME+1], 1);
        repeat (FRAME + 5) @(negedge clock);
        chk("b2b_third_frame_idle", bus.ocupado, 0);

        // reset during data bits of byte 1
        startFrame(16'h0407, 1'b1);
        capture(250, 1'b0, 60, 3);
        chk("mrst_line", lineH[61], 1);
        chk("mrst_ocupado", ocH[61], 0);
        cntOc = 0; cntPr = 0;
        for (int t = 61; t < 250; t++) begin
            if (ocH[t]) cntOc++;
            if (prH[t]) cntPr++;
        end
        chk("mrst_no_resume", cntOc, 0);
        chk("mrst_no_pronto", cntPr, 0);
        chk("mrst_estado", bus.db_estado, 0);

        startFrame(16'h0205, 1'b1);
        capture(205, 1'b0, -5, 0);
        checkFrame("after_rst", 0, 40'h32_35_2C_31_0A);
        chk("after_rst_pronto", prH[FRAME], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
